// File: rtl/tb_meas_pkg.sv
// Shared types and constants for the bench clock frequency meter.
// Nominal counts assume a 40 us gate (10000 cycles of clk_250m).
package tb_meas_pkg;

    typedef enum logic [1:0] {WARMUP, IDLE, GATE, REPORT} fm_state_e;

    localparam int unsigned WARMUP_CYCLES = 4;

    // clk_250m has no entry: it is the gate clock itself
    localparam int unsigned NOM_CNT_500M = 20000;
    localparam int unsigned NOM_CNT_100M = 4000;
    localparam int unsigned NOM_CNT_50M  = 2000;
    localparam int unsigned NOM_CNT_10M  = 400;
    localparam int unsigned NOM_CNT_1M   = 40;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser for an asynchronous clock-like input, followed by a
// one-cycle rising-edge pulse.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic edge_pulse
);

    logic s1, s2, s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign edge_pulse = s2 & ~s3;

endmodule

// File: rtl/clk_freq_meter.sv
// Counts rising edges of sig_in over a fixed window of clk cycles and grades
// the count against an expected value with a +/-TOL tolerance.
module clk_freq_meter
    import tb_meas_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = 10000,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned TOL         = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             start,
    input  logic [CNT_W-1:0] exp_cnt,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] meas_cnt,
    output logic             pass,
    output logic             fail_lo,
    output logic             fail_hi,
    output logic             stuck
);

    localparam int unsigned GW = $clog2(GATE_CYCLES + 1);
    localparam int unsigned WW = $clog2(WARMUP_CYCLES + 1);
    localparam int unsigned DW = CNT_W + 2;

    fm_state_e         state, state_nx;
    logic [GW-1:0]     gate_cnt;
    logic [WW-1:0]     warm_cnt;
    logic [CNT_W-1:0]  edge_cnt, cnt_nx, exp_q;
    logic              edge_pulse, gate_last, warm_last;
    logic signed [DW-1:0] diff, tol_s;
    logic              cmp_lo, cmp_hi, cmp_pass;

    sync_edge_det u_sync (
        .clk        (clk),
        .rst        (rst),
        .sig_in     (sig_in),
        .edge_pulse (edge_pulse)
    );

    assign gate_last = (gate_cnt == GW'(GATE_CYCLES - 1));
    assign warm_last = (warm_cnt == WW'(WARMUP_CYCLES - 1));

    // Include the edge seen on the final gate cycle in the reported count.
    assign cnt_nx = (edge_pulse && (edge_cnt != '1)) ? edge_cnt + CNT_W'(1) : edge_cnt;

    // Two guard bits keep exp-TOL and exp+TOL from wrapping at either end.
    assign tol_s    = DW'(TOL);
    assign diff     = $signed({2'b00, cnt_nx}) - $signed({2'b00, exp_q});
    assign cmp_lo   = (diff < -tol_s);
    assign cmp_hi   = (diff > tol_s);
    assign cmp_pass = !cmp_lo && !cmp_hi;

    always_ff @(posedge clk) begin
        if (rst) state <= WARMUP;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            WARMUP: if (warm_last) state_nx = IDLE;
            IDLE:   if (start) state_nx = GATE;
            GATE: begin
                busy = 1'b1;
                if (gate_last) state_nx = REPORT;
            end
            REPORT: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = WARMUP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            warm_cnt <= '0;
            gate_cnt <= '0;
            edge_cnt <= '0;
            exp_q    <= '0;
            meas_cnt <= '0;
            pass     <= 1'b0;
            fail_lo  <= 1'b0;
            fail_hi  <= 1'b0;
            stuck    <= 1'b0;
        end else begin
            case (state)
                WARMUP: warm_cnt <= warm_cnt + WW'(1);
                IDLE: begin
                    if (start) begin
                        exp_q    <= exp_cnt;
                        edge_cnt <= '0;
                        gate_cnt <= '0;
                    end
                end
                GATE: begin
                    gate_cnt <= gate_cnt + GW'(1);
                    edge_cnt <= cnt_nx;
                    if (gate_last) begin
                        meas_cnt <= cnt_nx;
                        pass     <= cmp_pass;
                        fail_lo  <= cmp_lo;
                        fail_hi  <= cmp_hi;
                        stuck    <= (cnt_nx == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_clk_freq_meter.sv
// Scoreboard bench for clk_freq_meter: stimulus pushes expected results,
// per-instance monitors pop and grade them whenever done pulses.
`timescale 1ns/100ps
module tb_clk_freq_meter;
    import tb_meas_pkg::*;

    typedef struct {
        int lo;
        int hi;
        bit p;
        bit fl;
        bit fh;
        bit st;
        int dcyc;
        int blen;
    } exp_t;

    exp_t q_main[$];
    exp_t q8[$];

    int checks = 0;
    int passes = 0;
    int cyc    = 0;
    int bl_main = 0;
    int bl8     = 0;

    logic clk = 1'b0;
    logic clk_1m, clk_10m, clk_50m, clk_100m;
    logic [2:0] sel;
    logic sig_main;

    // main instance (default geometry)
    logic        rst, start, busy, done, pass, fail_lo, fail_hi, stuck;
    logic [15:0] exp_cnt, meas_cnt;

    // narrow instance for saturation / bound tests
    logic       rst8, start8, busy8, done8, pass8, fl8, fh8, st8;
    logic [7:0] exp8, meas8;

    always #2 clk = ~clk;
    initial begin clk_100m = 1'b0; #0.3; forever #5   clk_100m = ~clk_100m; end
    initial begin clk_50m  = 1'b0; #0.3; forever #10  clk_50m  = ~clk_50m;  end
    initial begin clk_10m  = 1'b0; #0.3; forever #50  clk_10m  = ~clk_10m;  end
    initial begin clk_1m   = 1'b0; #0.3; forever #500 clk_1m   = ~clk_1m;   end

    always_comb begin
        case (sel)
            3'd1:    sig_main = clk_1m;
            3'd2:    sig_main = clk_10m;
            3'd3:    sig_main = clk_50m;
            3'd4:    sig_main = clk_100m;
            3'd5:    sig_main = 1'b1;
            default: sig_main = 1'b0;
        endcase
    end

    always @(posedge clk) cyc <= cyc + 1;

    clk_freq_meter #(.GATE_CYCLES(10000), .CNT_W(16), .TOL(2)) dut (
        .clk(clk), .rst(rst), .sig_in(sig_main), .start(start), .exp_cnt(exp_cnt),
        .busy(busy), .done(done), .meas_cnt(meas_cnt), .pass(pass),
        .fail_lo(fail_lo), .fail_hi(fail_hi), .stuck(stuck)
    );

    clk_freq_meter #(.GATE_CYCLES(1000), .CNT_W(8), .TOL(2)) dut8 (
        .clk(clk), .rst(rst8), .sig_in(clk_100m), .start(start8), .exp_cnt(exp8),
        .busy(busy8), .done(done8), .meas_cnt(meas8), .pass(pass8),
        .fail_lo(fl8), .fail_hi(fh8), .stuck(st8)
    );

    task automatic chk(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act >= lo && act <= hi) passes++;
        else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    endtask

    task automatic score(input string tag, input exp_t e, input int br, input int m,
                         input bit p, input bit fl, input bit fh, input bit st);
        chk({tag, "_done_cycle"}, cyc, e.dcyc, e.dcyc);
        chk({tag, "_busy_len"}, br, e.blen, e.blen);
        chk({tag, "_meas_cnt"}, m, e.lo, e.hi);
        chk({tag, "_pass"}, int'(p), int'(e.p), int'(e.p));
        chk({tag, "_fail_lo"}, int'(fl), int'(e.fl), int'(e.fl));
        chk({tag, "_fail_hi"}, int'(fh), int'(e.fh), int'(e.fh));
        chk({tag, "_stuck"}, int'(st), int'(e.st), int'(e.st));
    endtask

    always @(negedge clk) begin
        if (rst || !busy) bl_main = 0;
        else              bl_main++;
        if (done) begin
            if (q_main.size() == 0) chk("main_unexpected_done", 1, 0, 0);
            else score("main", q_main.pop_front(), bl_main, int'(meas_cnt),
                       pass, fail_lo, fail_hi, stuck);
        end
    end

    always @(negedge clk) begin
        if (rst8 || !busy8) bl8 = 0;
        else                bl8++;
        if (done8) begin
            if (q8.size() == 0) chk("w8_unexpected_done", 1, 0, 0);
            else score("w8", q8.pop_front(), bl8, int'(meas8), pass8, fl8, fh8, st8);
        end
    end

    task automatic wait_main(input int budget, input string tag);
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (done) return;
        end
        chk({tag, "_timeout"}, 1, 0, 0);
    endtask

    task automatic wait8(input int budget, input string tag);
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (done8) return;
        end
        chk({tag, "_timeout"}, 1, 0, 0);
    endtask

    // Select the source, let the synchroniser settle, then request one window.
    task automatic issue(input logic [2:0] s, input int e, input int lo, input int hi,
                         input bit p, input bit fl, input bit fh, input bit st, input bit push);
        exp_t x;
        sel = s;
        repeat (4) @(negedge clk);
        exp_cnt = 16'(e);
        start   = 1'b1;
        x = '{lo: lo, hi: hi, p: p, fl: fl, fh: fh, st: st, dcyc: cyc + 1 + 10000, blen: 10001};
        if (push) q_main.push_back(x);
        @(negedge clk);
        start   = 1'b0;
        exp_cnt = 16'hBEEF;
    endtask

    task automatic issue8(input int e, input int lo, input int hi,
                          input bit p, input bit fl, input bit fh);
        exp_t x;
        exp8   = 8'(e);
        start8 = 1'b1;
        x = '{lo: lo, hi: hi, p: p, fl: fl, fh: fh, st: 1'b0, dcyc: cyc + 1 + 1000, blen: 1001};
        q8.push_back(x);
        @(negedge clk);
        start8 = 1'b0;
        exp8   = 8'h5A;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sel = 3'd0; exp_cnt = '0;
        rst8 = 1'b1; start8 = 1'b0; exp8 = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0, 0);
        chk("rst_done", int'(done), 0, 0);
        chk("rst_meas_cnt", int'(meas_cnt), 0, 0);
        chk("rst_flags", int'({pass, fail_lo, fail_hi, stuck}), 0, 0);
        rst  = 1'b0;
        rst8 = 1'b0;
        repeat (6) @(negedge clk);

        fork
            begin
                // 10 MHz against its nominal count
                issue(3'd2, NOM_CNT_10M, 399, 401, 1, 0, 0, 0, 1);
                wait_main(10100, "t1");
                // 1 MHz graded against a too-high expectation
                issue(3'd1, 50, NOM_CNT_1M - 1, NOM_CNT_1M + 1, 0, 1, 0, 0, 1);
                wait_main(10100, "t2");
                // dead input
                issue(3'd0, 400, 0, 0, 0, 1, 0, 1, 1);
                wait_main(10100, "t3");
                // start held: two back-to-back windows at 50 MHz
                sel = 3'd3;
                repeat (4) @(negedge clk);
                exp_cnt = 16'(NOM_CNT_50M);
                start   = 1'b1;
                for (int k = 0; k < 2; k++)
                    q_main.push_back('{lo: 1999, hi: 2001, p: 1, fl: 0, fh: 0, st: 0,
                                       dcyc: cyc + 1 + 10000 + k * 10002, blen: 10001});
                wait_main(10100, "t4a");
                wait_main(10100, "t4b");
                start = 1'b0;
                // abort mid-window; outputs still hold the previous pass result
                issue(3'd2, 400, 0, 0, 0, 0, 0, 0, 0);
                repeat (4998) @(negedge clk);
                rst = 1'b1;
                sel = 3'd5;
                @(negedge clk);
                chk("abort_busy", int'(busy), 0, 0);
                chk("abort_done", int'(done), 0, 0);
                chk("abort_meas_cnt", int'(meas_cnt), 0, 0);
                chk("abort_flags", int'({pass, fail_lo, fail_hi, stuck}), 0, 0);
                @(negedge clk);
                rst   = 1'b0;
                start = 1'b1;
                repeat (4) @(negedge clk);
                chk("warmup_start_ignored", int'(busy), 0, 0);
                start = 1'b0;
                repeat (4) @(negedge clk);
                chk("warmup_idle_after", int'(busy), 0, 0);
                issue(3'd2, 400, 399, 401, 1, 0, 0, 0, 1);
                wait_main(10100, "t5");
                repeat (3) @(negedge clk);
            end
            begin
                // 100 MHz gives 400 edges per 1000-cycle window, beyond 8 bits
                issue8(200, 255, 255, 0, 0, 1);
                wait8(1100, "t6a");
                repeat (2) @(negedge clk);
                issue8(254, 255, 255, 1, 0, 0);
                wait8(1100, "t6b");
                repeat (2) @(negedge clk);
                issue8(255, 255, 255, 1, 0, 0);
                wait8(1100, "t6c");
            end
        join

        chk("main_missed_done", q_main.size(), 0, 0);
        chk("w8_missed_done", q8.size(), 0, 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
